// File: rtl/router_input_unit.sv
// Router input port: flit FIFO plus XY route lock from head to tail; 1-cycle write-to-output latency.
// Backpressure: in_ready drops when the FIFO is full (no bypass); pops only on forward.
module router_input_unit #(
  parameter int FlitWidth = 34,
  parameter int Depth     = 4,
  parameter int PosWidth  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PosWidth-1:0]  position_x,
  input  logic [PosWidth-1:0]  position_y,
  input  logic                 in_valid,
  input  logic [FlitWidth-1:0] in_flit,
  output logic                 in_ready,
  output logic [FlitWidth-1:0] out_flit,
  output logic                 out_head,
  output logic                 out_tail,
  output logic [4:0]           out_request,
  input  logic                 forward,
  output logic                 protocol_error
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL = (AW+1)'(Depth);

  typedef enum logic {IDLE, PACKET} state_t;

  logic [FlitWidth-1:0] mem [Depth];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  state_t               state_q, state_d;
  logic [4:0]           route_q, route_d, front_route;
  logic                 empty, f_head, f_tail;
  logic                 wr_en, rd_en, err_set;
  logic [FlitWidth-1:0] front;

  // Request bits: 0 North, 1 South, 2 West, 3 East, 4 Local.
  function automatic logic [4:0] xy_route(input logic [PosWidth-1:0] dx, input logic [PosWidth-1:0] dy,
                                          input logic [PosWidth-1:0] px, input logic [PosWidth-1:0] py);
    if (dx > px)      return 5'b01000;
    else if (dx < px) return 5'b00100;
    else if (dy > py) return 5'b00010;
    else if (dy < py) return 5'b00001;
    else              return 5'b10000;
  endfunction

  assign empty       = (count == '0);
  assign front       = mem[rd_ptr];
  assign f_head      = front[FlitWidth-1];
  assign f_tail      = front[FlitWidth-2];
  assign front_route = xy_route(front[PosWidth-1:0], front[2*PosWidth-1:PosWidth], position_x, position_y);

  assign in_ready = (count < FULL) & ~rst;
  assign wr_en    = in_valid & in_ready;
  assign out_flit = front;
  assign out_head = ~empty & f_head;
  assign out_tail = ~empty & f_tail;

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    out_request = '0;
    rd_en       = 1'b0;
    err_set     = forward & empty;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (f_head) begin
            out_request = front_route;
            if (forward) begin
              rd_en = 1'b1;
              if (!f_tail) begin
                state_d = PACKET;
                route_d = front_route;
              end
            end
          end else begin
            // Body flit with no open packet: stall until reset.
            err_set = 1'b1;
          end
        end
      end
      PACKET: begin
        if (!empty) begin
          out_request = route_q;
          rd_en       = forward;
          if (f_head) err_set = 1'b1;
          if (forward && f_tail) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      state_q        <= IDLE;
      route_q        <= '0;
      protocol_error <= 1'b0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      state_q <= state_d;
      route_q <= route_d;
      if (err_set) protocol_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_flit;
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Bench for router_input_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_router_input_unit;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [2:0]  position_x, position_y;
  logic        in_valid, in_ready, forward;
  logic [33:0] in_flit, out_flit;
  logic        out_head, out_tail, protocol_error;
  logic [4:0]  out_request;

  int checks = 0;
  int errors = 0;

  logic [33:0] q[$];
  bit          m_pkt;
  logic [4:0]  m_route;
  bit          m_err;

  router_input_unit #(.FlitWidth(34), .Depth(DEPTH), .PosWidth(3)) dut (
    .clk(clk), .rst(rst), .position_x(position_x), .position_y(position_y),
    .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .out_flit(out_flit), .out_head(out_head), .out_tail(out_tail),
    .out_request(out_request), .forward(forward), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(bit h, bit t, int unsigned dx, int unsigned dy, int unsigned pl);
    logic [33:0] f;
    f = '0;
    f[33] = h;
    f[32] = t;
    f[2:0] = dx[2:0];
    f[5:3] = dy[2:0];
    f[31:6] = pl[25:0];
    return f;
  endfunction

  function automatic logic [4:0] route_of(logic [33:0] f);
    int dx, dy, px, py;
    dx = int'(f[2:0]); dy = int'(f[5:3]);
    px = int'(position_x); py = int'(position_y);
    if (dx > px) return 5'b01000;
    if (dx < px) return 5'b00100;
    if (dy > py) return 5'b00010;
    if (dy < py) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [4:0] exp_req();
    if (q.size() == 0) return 5'b0;
    if (m_pkt) return m_route;
    if (q[0][33]) return route_of(q[0]);
    return 5'b0;
  endfunction

  // Advances the model with the inputs currently driven, then crosses one clock edge.
  task automatic tick();
    logic [33:0] f;
    bit acc;
    if (rst) begin
      q.delete(); m_pkt = 0; m_route = '0; m_err = 0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      if (forward && q.size() == 0) m_err = 1;
      if (q.size() > 0) begin
        f = q[0];
        if (!m_pkt && !f[33]) m_err = 1;
        if (m_pkt && f[33]) m_err = 1;
        if (forward && (m_pkt || f[33])) begin
          if (!m_pkt) begin
            if (!f[32]) begin m_pkt = 1; m_route = route_of(f); end
          end else if (f[32]) m_pkt = 0;
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back(in_flit);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drive(bit v, logic [33:0] f, bit fw);
    in_valid = v; in_flit = f; forward = fw;
  endtask

  task automatic test_reset();
    rst = 1; drive(0, '0, 0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b want 0", in_ready); end
    rst = 0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL reset_req got %b want 00000", out_request); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", protocol_error); end
    checks++; if (out_head !== 1'b0) begin errors++; $display("FAIL reset_head got %b want 0", out_head); end
  endtask

  task automatic test_single_flit();
    position_x = 3'd1; position_y = 3'd1;
    drive(1, mk(1, 1, 3, 1, 11), 0);
    tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b01000) begin errors++; $display("FAIL single_req got %b want 01000", out_request); end
    checks++; if ({out_head, out_tail} !== 2'b11) begin errors++; $display("FAIL single_ht got %b want 11", {out_head, out_tail}); end
    drive(0, '0, 1);
    tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL single_after_req got %b want 00000", out_request); end
    checks++; if (out_head !== 1'b0) begin errors++; $display("FAIL single_after_head got %b want 0", out_head); end
  endtask

  task automatic test_packet_bubble();
    position_x = 3'd2; position_y = 3'd2;
    drive(1, mk(1, 0, 2, 0, 21), 0); tick();
    checks++; if (out_request !== 5'b00001) begin errors++; $display("FAIL pkt_f1 got %b want 00001", out_request); end
    drive(1, mk(0, 0, 7, 7, 22), 1); tick();
    checks++; if (out_request !== 5'b00001) begin errors++; $display("FAIL pkt_f2 got %b want 00001", out_request); end
    drive(0, '0, 1); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL pkt_bubble1 got %b want 00000", out_request); end
    tick();
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL pkt_bubble2 got %b want 00000", out_request); end
    drive(1, mk(0, 0, 5, 5, 23), 0); tick();
    checks++; if (out_request !== 5'b00001) begin errors++; $display("FAIL pkt_f3 got %b want 00001", out_request); end
    drive(1, mk(0, 1, 0, 6, 24), 1); tick();
    checks++; if (out_request !== 5'b00001) begin errors++; $display("FAIL pkt_f4 got %b want 00001", out_request); end
    checks++; if (out_tail !== 1'b1) begin errors++; $display("FAIL pkt_tail got %b want 1", out_tail); end
    drive(0, '0, 1); tick();
    drive(1, mk(1, 1, 2, 2, 25), 0); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b10000) begin errors++; $display("FAIL pkt_local got %b want 10000", out_request); end
    drive(0, '0, 1); tick();
    drive(0, '0, 0);
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL pkt_err got %b want 0", protocol_error); end
  endtask

  task automatic test_fill();
    logic [33:0] want;
    drive(1, mk(1, 0, 2, 2, 100), 0); tick();
    for (int i = 1; i <= 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, in_ready); end
      drive(1, mk(0, 0, 7, 7, 100 + i), 0); tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", in_ready); end
    drive(1, mk(0, 0, 7, 7, 104), 1); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_after_pop got %b want 1", in_ready); end
    want = mk(0, 0, 7, 7, 101);
    checks++; if (out_flit !== want) begin errors++; $display("FAIL fill_front got %h want %h", out_flit, want); end
    drive(0, '0, 1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, mk(0, 0, 7, 7, 105 + i), 1); tick();
      want = (i == 0) ? mk(0, 0, 7, 7, 103) : mk(0, 0, 7, 7, 104 + i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_%0d got %b want 1", i, in_ready); end
      checks++; if (out_flit !== want) begin errors++; $display("FAIL wrap_front_%0d got %h want %h", i, out_flit, want); end
    end
    drive(0, '0, 1); tick(); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL wrap_drained got %b want 00000", out_request); end
    drive(1, mk(0, 1, 0, 0, 120), 0); tick();
    checks++; if (out_request !== 5'b10000) begin errors++; $display("FAIL wrap_locked got %b want 10000", out_request); end
    drive(0, '0, 1); tick();
    drive(0, '0, 0);
  endtask

  task automatic test_error();
    logic [33:0] b;
    rst = 1; tick(); rst = 0; tick();
    b = mk(0, 0, 4, 4, 200);
    drive(1, b, 0); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b0) begin errors++; $display("FAIL err_req got %b want 00000", out_request); end
    tick();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", protocol_error); end
    drive(0, '0, 1); tick(); drive(0, '0, 0);
    checks++; if (out_flit !== b) begin errors++; $display("FAIL err_stall got %h want %h", out_flit, b); end
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", protocol_error); end
    rst = 1; tick();
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", protocol_error); end
    rst = 0; tick();
    drive(0, '0, 1); tick(); drive(0, '0, 0);
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_empty_fwd got %b want 1", protocol_error); end
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_reset_mid_packet();
    position_x = 3'd2; position_y = 3'd2;
    drive(1, mk(1, 0, 0, 2, 300), 0); tick();
    drive(1, mk(0, 0, 0, 2, 301), 0); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b00100) begin errors++; $display("FAIL mid_west got %b want 00100", out_request); end
    rst = 1; tick(); rst = 0; tick();
    checks++; if ({out_request, out_head} !== 6'b0) begin errors++; $display("FAIL mid_flushed got %b want 000000", {out_request, out_head}); end
    drive(1, mk(1, 1, 4, 2, 302), 0); tick();
    drive(0, '0, 0);
    checks++; if (out_request !== 5'b01000) begin errors++; $display("FAIL mid_newhead got %b want 01000", out_request); end
    drive(0, '0, 1); tick(); drive(0, '0, 0);
  endtask

  task automatic test_random();
    logic [33:0] f;
    bit gen_pkt, h, t, acc;
    position_x = 3'($urandom_range(0, 7));
    position_y = 3'($urandom_range(0, 7));
    rst = 1; drive(0, '0, 0); tick();
    rst = 0; gen_pkt = 0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      h = !gen_pkt;
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) h = !h;
      f = mk(h, t, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      drive($urandom_range(0, 2) != 0, f,
            (q.size() > 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 49) == 0));
      acc = in_valid && !rst && (q.size() < DEPTH);
      if (rst) gen_pkt = 0;
      else if (acc) gen_pkt = !t;
      tick();
      checks++; if (in_ready !== (!rst && q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d got %b", i, in_ready); end
      checks++; if (out_request !== exp_req()) begin errors++; $display("FAIL rnd_req @%0d got %b want %b", i, out_request, exp_req()); end
      checks++; if (protocol_error !== m_err) begin errors++; $display("FAIL rnd_err @%0d got %b want %b", i, protocol_error, m_err); end
      checks++; if (out_head !== (q.size() > 0 && q[0][33])) begin errors++; $display("FAIL rnd_head @%0d got %b", i, out_head); end
      checks++; if (out_tail !== (q.size() > 0 && q[0][32])) begin errors++; $display("FAIL rnd_tail @%0d got %b", i, out_tail); end
      if (q.size() > 0) begin
        checks++; if (out_flit !== q[0]) begin errors++; $display("FAIL rnd_flit @%0d got %h want %h", i, out_flit, q[0]); end
      end
    end
    rst = 0; drive(0, '0, 0);
  endtask

  initial begin
    clk = 0; rst = 1; in_valid = 0; in_flit = '0; forward = 0;
    position_x = 3'd1; position_y = 3'd1;
    m_pkt = 0; m_route = '0; m_err = 0;
    test_reset();
    test_single_flit();
    test_packet_bubble();
    test_fill();
    test_error();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_unit.md
# router_input_unit

Input port stage of the 5-port mesh router, sitting directly upstream of the per-output router arbiters. It buffers incoming flits in a small FIFO, computes the XY dimension-order route from each head flit, locks that route until the tail flit, and presents a stable one-hot request vector plus the front flit to the crossbar/arbiters. A flit is popped when the downstream arbitration/crossbar signals it was forwarded.

## Interface

- FlitWidth, 34, flit width; bit FlitWidth-1 = head, bit FlitWidth-2 = tail
- Depth, 4, FIFO entries (power of two, ≥2)
- PosWidth, 3, width of each mesh coordinate; head flit carries dst_x = flit[PosWidth-1:0], dst_y = flit[2*PosWidth-1:PosWidth]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- position_x  in  PosWidth  this router's x coordinate (static)
- position_y  in  PosWidth  this router's y coordinate (static)
- in_valid  in  1  upstream flit valid
- in_flit  in  FlitWidth  upstream flit
- in_ready  out  1  FIFO can accept a flit this cycle
- out_flit  out  FlitWidth  FIFO front flit
- out_head  out  1  out_flit is a head flit and FIFO non-empty
- out_tail  out  1  out_flit is a tail flit and FIFO non-empty
- out_request  out  5  one-hot or zero; bit 0 North, 1 South, 2 West, 3 East, 4 Local
- forward  in  1  front flit was routed this cycle (pop)
- protocol_error  out  1  sticky error flag

## Operation

- FIFO: circular buffer, Depth entries, read/write pointers of log2(Depth) bits wrapping naturally, occupancy counter of log2(Depth)+1 bits.
- Write when in_valid & in_ready. Read when forward & (count != 0). forward with empty FIFO: ignored, sets protocol_error.
- in_ready = (count < Depth) & ~rst. No bypass: when full, in_ready = 0 even if forward is high this cycle.
- Simultaneous write and read with 0 < count < Depth: count unchanged, both pointers advance.
- Route function (XY): dst_x > position_x → East; dst_x < position_x → West; else dst_y > position_y → South; dst_y < position_y → North; else Local. Unsigned compare.
- State machine:
  - IDLE: expecting head. If FIFO non-empty and front is head: out_request = route(front), combinational from front flit. On forward: if front also tail (single-flit packet) stay IDLE; else latch route into route_q, go PACKET. If FIFO non-empty and front is not head: out_request = 0, set protocol_error, pop nothing (stall until reset).
  - PACKET: out_request = route_q when FIFO non-empty, 0 when empty (mid-packet bubble). A head flit at the front while in PACKET sets protocol_error; flit still forwarded on route_q. On forward of a tail flit: go IDLE.
- out_head/out_tail are 0 when FIFO empty; out_flit is don't-care when empty but driven from the read-pointer entry.
- protocol_error clears only on rst.

## Timing

- Reset values: count 0, pointers 0, state IDLE, route_q 0, out_request 0, out_head 0, out_tail 0, protocol_error 0, in_ready 0 during rst cycle, 1 in first cycle after.
- Write-to-output latency: 1 cycle (flit accepted at edge t appears on out_* after edge t; no fall-through).
- forward → pop at same edge; next front visible the following cycle.
- out_request changes only at clock edges (depends on registered FIFO/state), held stable for every flit of a packet, satisfying the arbiter's stable-request assumption.
- rst mid-packet: FIFO flushed, state IDLE, partial packet dropped.

## Test plan

- Reset then idle: after rst, in_ready=1, out_request=0, protocol_error=0, out_head=0.
- Single-flit packet at (1,1), dst (3,1), head+tail set: out_request=5'b01000 the cycle after write; forward → FIFO empty, out_request=0, state IDLE.
- 4-flit packet at (2,2) to dst (2,0): out_request=5'b00001 for all 4 flits, including a 2-cycle empty bubble (request 0) between flits 2 and 3; tail forward returns to IDLE; next packet to (2,2) yields 5'b10000.
- Fill: write 4 flits with no forward → in_ready=0 at count 4; in_valid with forward high while full is not accepted; after pop in_ready=1 next cycle; concurrent write+read at count 2 keeps count 2 over 10 cycles with pointer wrap.
- Error: body flit (head=0) first after reset → protocol_error=1 next cycle, out_request=0, stays set until rst; forward on empty FIFO also sets it.
- Reset mid-packet after 2 of 4 flits: FIFO empty, out_request=0, new head routes correctly.
